// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared state encoding and default operand width for the shift-add multiplier
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned multiplier, one add-and-shift step per clock
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mreg_q, mreg_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic                 accept;
  logic                 zero_op;
  logic                 last_step;

  assign accept    = (state_q == IDLE) && start;
  assign zero_op   = (a == '0) || (b == '0);
  assign last_step = (count_q == CW'(1));
  assign addend    = mreg_q[0] ? mcand_q : '0;
  // Keep the carry: sum is one bit wider than the accumulator.
  assign sum       = {1'b0, acc_q} + {1'b0, addend};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    mcand_d   = mcand_q;
    mreg_d    = mreg_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    if (accept) begin
      if (zero_op) begin
        product_d = '0;
      end else begin
        mcand_d = a;
        mreg_d  = b;
        acc_d   = '0;
        count_d = CW'(WIDTH);
      end
    end else if (state_q == RUN) begin
      // {acc,mreg} <= {c,sum,mreg} >> 1
      acc_d   = sum[WIDTH:1];
      mreg_d  = {sum[0], mreg_q[WIDTH-1:1]};
      count_d = count_q - CW'(1);
      if (last_step) begin
        product_d = {acc_d, mreg_d};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mreg_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mreg_q    <= mreg_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed and random self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int errors;
  int checks;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Independent reference used to cross-check the product.
  function automatic logic [15:0] restoring_div(input logic [15:0] n, input logic [7:0] d);
    logic [16:0] r;
    logic [15:0] q;
    r = '0;
    q = n;
    for (int i = 0; i < 16; i++) begin
      r = {r[15:0], q[15]};
      q = {q[14:0], 1'b0};
      if (r >= {9'b0, d}) begin
        r    = r - {9'b0, d};
        q[0] = 1'b1;
      end
    end
    return q;
  endfunction

  // Issues one start from IDLE and waits for done; caller is left in the DONE cycle.
  task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb_op,
                         output int lat, output int nbusy,
                         output logic [15:0] prod, output bit timed_out);
    int guard;
    guard = 0;
    while ((busy || done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a     = ta;
    b     = tb_op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    timed_out = !done;
    prod      = product;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'd5;
    b     = 8'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (product !== 16'd0) begin errors++; $display("FAIL reset_product: got %0d expected 0", product); end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int va[5] = '{13, 1, 128, 255, 1};
    int vb[5] = '{11, 1, 2, 1, 255};
    int ve[5] = '{143, 1, 256, 255, 255};
    int lat, nbusy;
    logic [15:0] prod;
    bit to;
    for (int i = 0; i < 5; i++) begin
      do_mult(8'(va[i]), 8'(vb[i]), lat, nbusy, prod, to);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout %0d*%0d: no done within 40 cycles", va[i], vb[i]); end
      checks++;
      if (prod !== 16'(ve[i])) begin errors++; $display("FAIL basic_product %0d*%0d: got %0d expected %0d", va[i], vb[i], prod, ve[i]); end
      checks++;
      if (nbusy != 8) begin errors++; $display("FAIL basic_busy_cycles %0d*%0d: got %0d expected 8", va[i], vb[i], nbusy); end
      checks++;
      if (lat != 9) begin errors++; $display("FAIL basic_latency %0d*%0d: got %0d expected 9", va[i], vb[i], lat); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || product !== 16'(ve[i])) begin
        errors++;
        $display("FAIL basic_done_pulse %0d*%0d: got done=%b product=%0d expected done=0 product=%0d", va[i], vb[i], done, product, ve[i]);
      end
    end
  endtask

  task automatic test_max();
    int lat, nbusy;
    logic [15:0] prod;
    bit to;
    do_mult(8'd255, 8'd255, lat, nbusy, prod, to);
    checks++;
    if (to) begin errors++; $display("FAIL max_timeout: no done within 40 cycles"); end
    checks++;
    if (prod !== 16'd65025) begin errors++; $display("FAIL max_product: got %0d expected 65025", prod); end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL max_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_zero();
    int va[2] = '{0, 7};
    int vb[2] = '{200, 0};
    int lat, nbusy;
    logic [15:0] prod;
    bit to;
    for (int i = 0; i < 2; i++) begin
      do_mult(8'(va[i]), 8'(vb[i]), lat, nbusy, prod, to);
      checks++;
      if (to) begin errors++; $display("FAIL zero_timeout %0d*%0d: no done within 40 cycles", va[i], vb[i]); end
      checks++;
      if (prod !== 16'd0) begin errors++; $display("FAIL zero_product %0d*%0d: got %0d expected 0", va[i], vb[i], prod); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL zero_latency %0d*%0d: got %0d expected 1", va[i], vb[i], lat); end
      checks++;
      if (nbusy != 0) begin errors++; $display("FAIL zero_busy %0d*%0d: got %0d busy cycles expected 0", va[i], vb[i], nbusy); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_after %0d*%0d: got busy=%b done=%b expected 0 0", va[i], vb[i], busy, done);
      end
      // Leave product nonzero so the next zero case cannot pass on a stale value.
      if (i == 0) do_mult(8'd2, 8'd3, lat, nbusy, prod, to);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int guard;
    guard = 0;
    while ((busy || done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a     = 8'd3;
    b     = 8'd5;
    start = 1'b1;
    @(negedge clk);
    // Expected cycle pattern with start held: 8 RUN, 1 DONE, 1 IDLE, repeat.
    for (int i = 1; i <= 30; i++) begin
      p = (i - 1) % 10;
      checks++;
      if (busy !== (p < 8)) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b expected %b", i, busy, (p < 8)); end
      checks++;
      if (done !== (p == 8)) begin errors++; $display("FAIL b2b_done cycle %0d: got %b expected %b", i, done, (p == 8)); end
      if (p == 8) begin
        checks++;
        if (product !== 16'd15) begin errors++; $display("FAIL b2b_product cycle %0d: got %0d expected 15", i, product); end
      end
      if (p == 2) begin a = 8'd200; b = 8'd100; end
      if (p == 6) begin a = 8'd3;   b = 8'd5;   end
      if (i == 30) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    int lat, nbusy;
    logic [15:0] prod;
    bit to;
    a     = 8'd100;
    b     = 8'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_run: got busy=%b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b product=%0d expected 0 0 0", busy, done, product);
    end
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
    do_mult(8'd100, 8'd50, lat, nbusy, prod, to);
    checks++;
    if (to || prod !== 16'd5000) begin errors++; $display("FAIL abort_restart: got %0d timeout=%b expected 5000", prod, to); end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_random();
    logic [7:0]  ra, rb;
    logic [15:0] expv, prod;
    int lat, nbusy, exp_lat;
    bit to;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      expv    = {8'b0, ra} * {8'b0, rb};
      exp_lat = (ra == 8'd0 || rb == 8'd0) ? 1 : 9;
      do_mult(ra, rb, lat, nbusy, prod, to);
      checks++;
      if (to || prod !== expv || lat != exp_lat) begin
        errors++;
        $display("FAIL random %0d*%0d: got %0d lat=%0d expected %0d lat=%0d", ra, rb, prod, lat, expv, exp_lat);
      end
      if (rb != 8'd0) begin
        checks++;
        if (restoring_div(prod, rb) !== {8'b0, ra}) begin
          errors++;
          $display("FAIL random_div %0d/%0d: got %0d expected %0d", prod, rb, restoring_div(prod, rb), ra);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 4 to 16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled on each clk edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned multiplicand, sampled when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned multiplier, sampled when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse; product is valid in the same cycle.
REQ-009 The block SHALL have port product, output, 2*WIDTH bits: registered result, held until the next accepted start.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-011 The block SHALL accept start only in IDLE; start in RUN or DONE SHALL be ignored, and the operands SHALL NOT be resampled.
REQ-012 On accept with a!=0 and b!=0, the block SHALL load mcand=a, mreg=b, acc=0 and count=WIDTH, and go to RUN.
REQ-013 On accept with a==0 or b==0, the block SHALL load product=0 and go directly to DONE (early exit, no RUN cycles).
REQ-014 In each RUN cycle, the block SHALL compute {c,sum} = acc + (mreg[0] ? mcand : 0) at WIDTH+1 bits, then set {acc,mreg} = {c,sum,mreg} >> 1, and decrement count.
REQ-015 When RUN completes the cycle in which count==1, the block SHALL write product={acc,mreg} (the post-shift values) and go to DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-017 Latency, with start accepted at edge k: nonzero operands SHALL give done high in the cycle after edge k+WIDTH+1 (WIDTH RUN cycles plus one DONE cycle); a zero operand SHALL give done in the cycle after edge k+1.
REQ-018 The result SHALL satisfy product == a*b exactly for all unsigned operands, with no truncation; the carry c SHALL never be dropped.
REQ-019 Operand changes on a/b after acceptance SHALL NOT affect the result in flight.
REQ-020 Back-to-back: start high in the DONE cycle SHALL be ignored; start high in the following IDLE cycle SHALL be accepted.

Reset
REQ-021 rst SHALL force state=IDLE, busy=0, done=0, product=0, acc=0, mreg=0, mcand=0 and count=0 on the next clk edge.
REQ-022 rst SHALL take priority over start and over any in-flight RUN; the aborted operation SHALL produce no done pulse.
REQ-023 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant; the counter width SHALL be $clog2(WIDTH+1).
REQ-025 The block SHALL be a single module with no sub-module; the datapath is one adder plus one shift register.

Verification
REQ-026 The bench SHALL cover WIDTH=8, a=13, b=11, one start pulse -> busy for 8 cycles, then done for 1 cycle with product=143.
REQ-027 The bench SHALL cover a=255, b=255 -> product=65025 (carry path exercised), with done 9 cycles after accept.
REQ-028 The bench SHALL cover a=0, b=200 -> done 1 cycle after accept with product=0 and busy never high; then a=7, b=0 gives the same behaviour.
REQ-029 The bench SHALL cover start held high continuously with a=3, b=5 -> product=15 on each done, with exactly one IDLE cycle between consecutive DONE and RUN sequences, and a/b changes mid-RUN having no effect.
REQ-030 The bench SHALL cover rst asserted on the 4th RUN cycle of a=100, b=50 -> no done, all outputs 0 next cycle; a following start with a=100, b=50 gives product=5000.
REQ-031 The bench SHALL cover a random sweep of 1000 operand pairs against the a*b reference model, plus a cross-check that feeding product and b to the team's restoring divider returns quotient a.
